// File: rtl/imidiate_genarator.sv
// RV32IM decode-stage immediate generator: format-selected, sign-extended, registered.
// Optional macro IMMGEN_SHAMT_EN adds the shift-amount format on type code 101.
module imidiate_genarator (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [31:0] INSTRUCTION,
    input  logic [2:0]  IMMEDIATE_TYPE,
    output logic [31:0] IMMEDIATE_VALUE
);

    typedef enum logic [2:0] {
        IMM_I     = 3'b000,
        IMM_S     = 3'b001,
        IMM_B     = 3'b010,
        IMM_U     = 3'b011,
        IMM_J     = 3'b100,
        IMM_SHAMT = 3'b101,
        IMM_RSV6  = 3'b110,
        IMM_RSV7  = 3'b111
    } imm_type_t;

    imm_type_t   imm_type;
    logic        sign_bit;
    logic [31:0] imm_next;
    logic [31:0] imm_reg;

    assign imm_type = imm_type_t'(IMMEDIATE_TYPE);
    // Every signed format takes its sign from bit 31 of the instruction.
    assign sign_bit = INSTRUCTION[31];

    always_comb begin
        imm_next = 32'h0;
        unique case (imm_type)
            IMM_I: imm_next = {{20{sign_bit}}, INSTRUCTION[31:20]};
            IMM_S: imm_next = {{20{sign_bit}}, INSTRUCTION[31:25], INSTRUCTION[11:7]};
            IMM_B: imm_next = {{19{sign_bit}}, INSTRUCTION[31], INSTRUCTION[7],
                               INSTRUCTION[30:25], INSTRUCTION[11:8], 1'b0};
            IMM_U: imm_next = {INSTRUCTION[31:12], 12'h000};
            IMM_J: imm_next = {{11{sign_bit}}, INSTRUCTION[31], INSTRUCTION[19:12],
                               INSTRUCTION[20], INSTRUCTION[30:21], 1'b0};
`ifdef IMMGEN_SHAMT_EN
            IMM_SHAMT: imm_next = {27'h0, INSTRUCTION[24:20]};
`else
            IMM_SHAMT: imm_next = 32'h0;
`endif
            IMM_RSV6,
            IMM_RSV7:  imm_next = 32'h0;
            default:   imm_next = 32'h0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            imm_reg <= 32'h0;
        end else begin
            imm_reg <= imm_next;
        end
    end

    assign IMMEDIATE_VALUE = imm_reg;

endmodule

// File: tb/tb_imidiate_genarator.sv
// Directed-vector bench for imidiate_genarator; expected values are hand-computed.
`timescale 1ns/1ps
module tb_imidiate_genarator;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic [2:0]  imm_type;
    logic [31:0] imm_value;

    int n_checks = 0;
    int n_fail   = 0;

    imidiate_genarator dut (
        .CLK             (clk),
        .RESET_N         (rst_n),
        .INSTRUCTION     (instr),
        .IMMEDIATE_TYPE  (imm_type),
        .IMMEDIATE_VALUE (imm_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, actual, expected);
        end else begin
            $display("ok   %s: %08h", tag, actual);
        end
    endtask

    // Drive away from the edge, take one posedge, sample 1ns later.
    task automatic apply(input string tag, input logic [31:0] i, input logic [2:0] t,
                         input logic [31:0] expected);
        @(negedge clk);
        instr    = i;
        imm_type = t;
        @(posedge clk);
        #1;
        check_value(tag, imm_value, expected);
    endtask

    logic [31:0] shamt_expected;

    initial begin
`ifdef IMMGEN_SHAMT_EN
        shamt_expected = 32'h0000001F;
`else
        shamt_expected = 32'h00000000;
`endif
        rst_n    = 1'b0;
        instr    = 32'h12345678;
        imm_type = 3'b000;
        #2;
        check_value("reset_state", imm_value, 32'h0);
        @(posedge clk);
        #1;
        check_value("reset_held_over_edge", imm_value, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        apply("i_type",        32'h12345678, 3'b000, 32'h00000123);
        apply("s_type",        32'h87654321, 3'b001, 32'hFFFFF866);
        apply("b_type",        32'hFEDCBA98, 3'b010, 32'hFFFFFFF4);
        apply("u_type",        32'h0ABCDEF0, 3'b011, 32'h0ABCD000);
        apply("i_type_neg",    32'hFFF00093, 3'b000, 32'hFFFFFFFF);
        apply("s_type_pos",    32'h7E000F80, 3'b001, 32'h000007FF);
        apply("b_type_pos",    32'h7E000F80, 3'b010, 32'h00000FFE);
        apply("j_type_pos",    32'h7FFFF000, 3'b100, 32'h000FFFFE);
        apply("u_type_top",    32'hFFFFF000, 3'b011, 32'hFFFFF000);
        apply("type_110",      32'hFFFFFFFF, 3'b110, 32'h0);
        apply("type_111",      32'hFFFFFFFF, 3'b111, 32'h0);
        apply("shamt_101",     32'h01F00013, 3'b101, shamt_expected);
        apply("j_type",        32'hA1B2C3D4, 3'b100, 32'hFFF2CA1A);

        // Output must hold until the next edge even if inputs change.
        @(negedge clk);
        instr    = 32'h12345678;
        imm_type = 3'b000;
        #2;
        check_value("hold_between_edges", imm_value, 32'hFFF2CA1A);
        instr    = 32'hA1B2C3D4;
        imm_type = 3'b100;

        // Asynchronous reset between edges while output is nonzero.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_value("async_reset_now", imm_value, 32'h0);
        @(posedge clk);
        #1;
        check_value("async_reset_held", imm_value, 32'h0);
        #2;
        rst_n = 1'b1;
        #1;
        check_value("after_release_no_edge", imm_value, 32'h0);
        @(posedge clk);
        #1;
        check_value("after_release_edge", imm_value, 32'hFFF2CA1A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
